stage_if: RTL and testbench

Stage 1 (IF) of the MIPS 5-level pipeline: owns the PC, fetches from instruction memory over a ready-handshake, and drives the IF/ID register (`pc4_id`, `instr_id`) consumed by stage_id. Takes `pc_select`, `pc_b`, `pc_j`, `a_id` and `stall` back from ID. Implements one branch delay slot, load-use stall hold, a one-entry skid buffer, and redirect capture across multi-cycle fetches.

---
 rtl/stage_if_if.sv | 11 +
 rtl/stage_if.sv | 126 ++++++++++++
 tb/tb_stage_if.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stage_if_if.sv
// Instruction-memory fetch bus between the IF stage (master) and the
// instruction memory (slave): request/address out, data/ready back.
interface stage_if_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_data, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_data, output imem_ready);
endinterface

// File: rtl/stage_if.sv
// MIPS pipeline stage 1 (IF): owns the PC, fetches over a ready handshake and
// drives the IF/ID register, with one delay slot, a skid entry and redirect capture.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset_0,
    stage_if_if.master       mem,
    input  logic             stall,
    input  logic [1:0]       pc_select,
    input  logic [31:0]      pc_b,
    input  logic [31:0]      pc_j,
    input  logic [31:0]      a_id,
    output logic [31:0]      pc4_id,
    output logic [31:0]      instr_id
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_reg,       state_next;
    logic [31:0] pc_reg,          pc_next;
    logic [31:0] pc4_id_reg,      pc4_id_next;
    logic [31:0] instr_id_reg,    instr_id_next;
    logic [31:0] skid_instr_reg,  skid_instr_next;
    logic [31:0] skid_pc4_reg,    skid_pc4_next;
    logic        redir_valid_reg, redir_valid_next;
    logic [31:0] redir_pc_reg,    redir_pc_next;

    logic        accept;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            pc4_id_reg      <= 32'h0;
            instr_id_reg    <= 32'h0;
            skid_instr_reg  <= 32'h0;
            skid_pc4_reg    <= 32'h0;
            redir_valid_reg <= 1'b0;
            redir_pc_reg    <= 32'h0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pc4_id_reg      <= pc4_id_next;
            instr_id_reg    <= instr_id_next;
            skid_instr_reg  <= skid_instr_next;
            skid_pc4_reg    <= skid_pc4_next;
            redir_valid_reg <= redir_valid_next;
            redir_pc_reg    <= redir_pc_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pc4_id_next      = pc4_id_reg;
        instr_id_next    = instr_id_reg;
        skid_instr_next  = skid_instr_reg;
        skid_pc4_next    = skid_pc4_reg;
        redir_valid_next = redir_valid_reg;
        redir_pc_next    = redir_pc_reg;

        pc_plus4 = pc_reg + 32'd4;
        accept   = ~stall;
        redirect = accept & (pc_select != 2'b00);
        case (pc_select)
            2'b01:   target = pc_b;
            2'b10:   target = a_id;
            2'b11:   target = pc_j;
            default: target = pc_plus4;
        endcase

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (mem.imem_ready) begin
                    redir_valid_next = 1'b0;
                    if (accept) begin
                        instr_id_next = mem.imem_data;
                        pc4_id_next   = pc_plus4;
                        // A live redirect beats one captured during an earlier wait.
                        if (redirect)
                            pc_next = target;
                        else if (redir_valid_reg)
                            pc_next = redir_pc_reg;
                        else
                            pc_next = pc_plus4;
                    end else begin
                        skid_instr_next = mem.imem_data;
                        skid_pc4_next   = pc_plus4;
                        pc_next         = redir_valid_reg ? redir_pc_reg : pc_plus4;
                        state_next      = HOLD;
                    end
                end else if (accept) begin
                    // The word in flight is the delay slot; park the target until it lands.
                    instr_id_next = 32'h0;
                    if (redirect) begin
                        redir_valid_next = 1'b1;
                        redir_pc_next    = target;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    instr_id_next = skid_instr_reg;
                    pc4_id_next   = skid_pc4_reg;
                    if (redirect)
                        pc_next = target;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem.imem_req  = (state_reg == FETCH);
    assign mem.imem_addr = pc_reg;
    assign pc4_id        = pc4_id_reg;
    assign instr_id      = instr_id_reg;
endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: each step drives one cycle of inputs and queues the
// hand-computed IF/ID and fetch-bus state expected after the following rising edge.
module tb_stage_if;
    logic        clock = 1'b0;
    logic        reset_0 = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pc_select = 2'b00;
    logic [31:0] pc_b = 32'h0000_0040;
    logic [31:0] pc_j = 32'h0000_0100;
    logic [31:0] a_id = 32'h0000_0080;
    logic [31:0] pc4_id;
    logic [31:0] instr_id;
    logic        rdy = 1'b1;

    int checks = 0;
    int failures = 0;
    int step_idx = 0;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t exp_q[$];

    stage_if_if bus();

    // Zero-wait-capable memory: word i holds i+1; readiness is driven per step.
    assign bus.imem_data  = (bus.imem_addr >> 2) + 32'd1;
    assign bus.imem_ready = rdy;

    stage_if #(.RESET_PC(32'h0000_0000)) dut (
        .clock     (clock),
        .reset_0   (reset_0),
        .mem       (bus),
        .stall     (stall),
        .pc_select (pc_select),
        .pc_b      (pc_b),
        .pc_j      (pc_j),
        .a_id      (a_id),
        .pc4_id    (pc4_id),
        .instr_id  (instr_id)
    );

    always #5 clock = ~clock;

    task automatic check(input int idx, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL step %0d %s: got %h expected %h", idx, name, act, req);
        end
    endtask

    // Monitor: after every rising edge, pop one expectation and compare.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.idx, "imem_req",  {31'h0, bus.imem_req}, {31'h0, e.req});
            check(e.idx, "imem_addr", bus.imem_addr, e.addr);
            check(e.idx, "instr_id",  instr_id, e.instr);
            check(e.idx, "pc4_id",    pc4_id, e.pc4);
            $display("step %0d: req=%0b addr=%h instr_id=%h pc4_id=%h", e.idx,
                     bus.imem_req, bus.imem_addr, instr_id, pc4_id);
        end
    end

    task automatic step(input logic rst, input logic r, input logic s, input logic [1:0] sel,
                        input logic [31:0] aid, input logic e_req, input logic [31:0] e_addr,
                        input logic [31:0] e_instr, input logic [31:0] e_pc4);
        exp_t e;
        @(negedge clock);
        reset_0   = rst;
        rdy       = r;
        stall     = s;
        pc_select = sel;
        a_id      = aid;
        e.idx   = step_idx;
        e.req   = e_req;
        e.addr  = e_addr;
        e.instr = e_instr;
        e.pc4   = e_pc4;
        exp_q.push_back(e);
        step_idx++;
    endtask

    localparam logic [31:0] A = 32'h0000_0080;

    initial begin
        // Reset state
        step(0, 1, 0, 2'b00, A, 0, 32'h0,   32'h0, 32'h0);
        step(0, 1, 0, 2'b00, A, 0, 32'h0,   32'h0, 32'h0);
        // Release: IDLE then sequential zero-wait fetch
        step(1, 1, 0, 2'b00, A, 1, 32'h0,   32'h0, 32'h0);
        step(1, 1, 0, 2'b00, A, 1, 32'h4,   32'h1, 32'h4);
        step(1, 1, 0, 2'b00, A, 1, 32'h8,   32'h2, 32'h8);
        step(1, 1, 0, 2'b00, A, 1, 32'hC,   32'h3, 32'hC);
        // Stall while fetch of 0x0C completes -> HOLD for two cycles
        step(1, 1, 1, 2'b00, A, 0, 32'h10,  32'h3, 32'hC);
        step(1, 1, 1, 2'b00, A, 0, 32'h10,  32'h3, 32'hC);
        step(1, 1, 0, 2'b00, A, 1, 32'h10,  32'h4, 32'h10);
        // Taken branch: delay slot enters ID, target on imem_addr
        step(1, 1, 0, 2'b01, A, 1, 32'h40,  32'h5, 32'h14);
        step(1, 1, 0, 2'b00, A, 1, 32'h44,  32'h11, 32'h44);
        // Jump during wait: bubbles, target applied when delay slot lands
        step(1, 0, 0, 2'b11, A, 1, 32'h44,  32'h0, 32'h44);
        step(1, 0, 0, 2'b00, A, 1, 32'h44,  32'h0, 32'h44);
        step(1, 1, 0, 2'b00, A, 1, 32'h100, 32'h12, 32'h48);
        step(1, 1, 0, 2'b00, A, 1, 32'h104, 32'h41, 32'h104);
        // jr under stall: redirect ignored, then taken from HOLD
        step(1, 1, 1, 2'b10, A, 0, 32'h108, 32'h41, 32'h104);
        step(1, 1, 0, 2'b10, A, 1, 32'h80,  32'h42, 32'h108);
        step(1, 1, 0, 2'b00, A, 1, 32'h84,  32'h21, 32'h84);
        // Wait with stall holds; wait without stall bubbles
        step(1, 0, 1, 2'b00, A, 1, 32'h84,  32'h21, 32'h84);
        step(1, 0, 0, 2'b00, A, 1, 32'h84,  32'h0, 32'h84);
        // Captured redirect consumed by a stalled completion
        step(1, 0, 0, 2'b01, A, 1, 32'h84,  32'h0, 32'h84);
        step(1, 1, 1, 2'b00, A, 0, 32'h40,  32'h0, 32'h84);
        step(1, 1, 0, 2'b00, A, 1, 32'h40,  32'h22, 32'h88);
        step(1, 1, 0, 2'b00, A, 1, 32'h44,  32'h11, 32'h44);
        // PC wrap at the top of the address space
        step(1, 1, 0, 2'b10, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h12, 32'h48);
        step(1, 1, 0, 2'b00, A, 1, 32'h0,   32'h4000_0000, 32'h0);
        step(1, 1, 0, 2'b00, A, 1, 32'h4,   32'h1, 32'h4);
        // Reset mid-fetch, then restart from RESET_PC
        step(1, 0, 1, 2'b00, A, 1, 32'h4,   32'h1, 32'h4);
        step(0, 0, 0, 2'b00, A, 0, 32'h0,   32'h0, 32'h0);
        step(1, 1, 0, 2'b00, A, 1, 32'h0,   32'h0, 32'h0);
        step(1, 1, 0, 2'b00, A, 1, 32'h4,   32'h1, 32'h4);
        step(1, 1, 0, 2'b00, A, 1, 32'h8,   32'h2, 32'h8);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
